// File: rtl/counter_sched.sv
// Round-robin scheduler/sequencer driving a shared 4-bit loadable up/down counter.
// Optional abort support is enabled with `define COUNTER_SCHED_ABORT_EN.
module counter_sched #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_start,
    input  logic              req0_ud,
    input  logic [STEP_W-1:0] req0_steps,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_start,
    input  logic              req1_ud,
    input  logic [STEP_W-1:0] req1_steps,
    output logic              cnt_load,
    output logic              cnt_ud,
    output logic [WIDTH-1:0]  cnt_data,
    input  logic [WIDTH-1:0]  cnt_q,
`ifdef COUNTER_SCHED_ABORT_EN
    input  logic              abort,
    output logic              done_aborted,
`endif
    output logic              busy,
    output logic              done_valid,
    output logic              done_id,
    output logic [WIDTH-1:0]  done_value
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last;
    logic                r_id;
    logic                r_ud;
    logic [WIDTH-1:0]    r_start;
    logic [STEP_W-1:0]   r_steps;
    logic [STEP_W-1:0]   r_remaining;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_abort_hit;

    // A lone valid wins; on a tie the requester not granted last wins.
    assign w_grant0 = (r_state == IDLE) && !reset && req0_valid && (!req1_valid || r_last);
    assign w_grant1 = (r_state == IDLE) && !reset && req1_valid && !w_grant0;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

`ifdef COUNTER_SCHED_ABORT_EN
    logic r_aborted;
    assign w_abort_hit  = abort && ((r_state == LOAD) || (r_state == RUN));
    assign done_aborted = (r_state == DONE) && r_aborted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aborted <= 1'b0;
        end else if ((r_state == LOAD) || (r_state == RUN)) begin
            r_aborted <= w_abort_hit;
        end else if (r_state == IDLE) begin
            r_aborted <= 1'b0;
        end
    end
`else
    assign w_abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_ud        <= 1'b0;
            r_start     <= '0;
            r_steps     <= '0;
            r_remaining <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_last  <= w_grant1;
                        r_id    <= w_grant1;
                        r_ud    <= w_grant1 ? req1_ud    : req0_ud;
                        r_start <= w_grant1 ? req1_start : req0_start;
                        r_steps <= w_grant1 ? req1_steps : req0_steps;
                    end
                end
                LOAD:    r_remaining <= r_steps;
                RUN:     r_remaining <= r_remaining - 1'b1;
                default: ;
            endcase
        end
    end

    // The counter has no enable, so every non-counting state reloads its own value.
    always_comb begin
        w_next   = r_state;
        cnt_load = 1'b1;
        cnt_ud   = 1'b0;
        cnt_data = cnt_q;
        case (r_state)
            IDLE: begin
                if (w_grant0 || w_grant1) w_next = LOAD;
            end
            LOAD: begin
                cnt_data = r_start;
                w_next   = (r_steps == '0) ? DONE : RUN;
            end
            RUN: begin
                cnt_load = 1'b0;
                cnt_ud   = r_ud;
                if (r_remaining == STEP_W'(1)) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort_hit) w_next = DONE;
    end

    assign busy       = (r_state != IDLE);
    assign done_valid = (r_state == DONE);
    assign done_id    = (r_state == DONE) ? r_id  : 1'b0;
    assign done_value = (r_state == DONE) ? cnt_q : '0;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural model of the shared counter.
module tb_counter_sched;
    localparam int WIDTH  = 4;
    localparam int STEP_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [WIDTH-1:0]  req0_start, req1_start;
    logic              req0_ud, req1_ud;
    logic [STEP_W-1:0] req0_steps, req1_steps;
    logic              cnt_load, cnt_ud;
    logic [WIDTH-1:0]  cnt_data;
    logic [WIDTH-1:0]  cnt_q = '0;
    logic              busy, done_valid, done_id;
    logic [WIDTH-1:0]  done_value;
`ifdef COUNTER_SCHED_ABORT_EN
    logic              abort;
    logic              done_aborted;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Loadable up/down counter with no enable.
    always @(posedge clk) begin
        if (cnt_load) cnt_q <= cnt_data;
        else          cnt_q <= cnt_ud ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    counter_sched #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_start(req0_start),
        .req0_ud(req0_ud), .req0_steps(req0_steps),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_start(req1_start),
        .req1_ud(req1_ud), .req1_steps(req1_steps),
        .cnt_load(cnt_load), .cnt_ud(cnt_ud), .cnt_data(cnt_data), .cnt_q(cnt_q),
`ifdef COUNTER_SCHED_ABORT_EN
        .abort(abort), .done_aborted(done_aborted),
`endif
        .busy(busy), .done_valid(done_valid), .done_id(done_id), .done_value(done_value)
    );

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", req0_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done_valid !== 1'b0 || done_id !== 1'b0 || done_value !== 4'd0) begin
            errors++; $display("FAIL reset_done: got valid=%b id=%b value=%0d expected 0/0/0", done_valid, done_id, done_value); end
        checks++; if (cnt_load !== 1'b1 || cnt_ud !== 1'b0 || cnt_data !== cnt_q) begin
            errors++; $display("FAIL reset_hold: got load=%b ud=%b data=%0d expected 1/0/%0d", cnt_load, cnt_ud, cnt_data, cnt_q); end
`ifdef COUNTER_SCHED_ABORT_EN
        checks++; if (done_aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted: got %b expected 0", done_aborted); end
`endif
        @(negedge clk);
        req0_valid = 1'b0;
        reset = 1'b0;
        $display("reset: released");
    endtask

    // One full command: handshake, exact completion cycle, then hold check.
    task automatic run_cmd(input bit id, input logic [3:0] start, input bit ud,
                           input int steps, input logic [3:0] exp_val);
        @(negedge clk);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_start = start; req0_ud = ud; req0_steps = STEP_W'(steps);
        end else begin
            req1_valid = 1'b1; req1_start = start; req1_ud = ud; req1_steps = STEP_W'(steps);
        end
        #1;
        checks++; if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL cmd_ready: got r1r0=%b%b expected grant to %0d", req1_ready, req0_ready, id); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL cmd_load_state: got r0=%b r1=%b busy=%b expected 0/0/1", req0_ready, req1_ready, busy); end
        checks++; if (cnt_load !== 1'b1 || cnt_data !== start) begin
            errors++; $display("FAIL cmd_load_drive: got load=%b data=%0d expected 1/%0d", cnt_load, cnt_data, start); end
        for (int k = 0; k < steps; k++) begin
            @(negedge clk);
            checks++; if (done_valid !== 1'b0) begin
                errors++; $display("FAIL cmd_early_done: got done_valid=1 at run cycle %0d expected 0", k); end
        end
        @(negedge clk);
        checks++; if (done_valid !== 1'b1 || done_id !== id || done_value !== exp_val) begin
            errors++; $display("FAIL cmd_done: got valid=%b id=%b value=%0d expected 1/%0d/%0d",
                               done_valid, done_id, done_value, id, exp_val); end
        @(negedge clk);
        checks++; if (done_valid !== 1'b0 || busy !== 1'b0 || cnt_q !== exp_val) begin
            errors++; $display("FAIL cmd_hold: got valid=%b busy=%b cnt=%0d expected 0/0/%0d", done_valid, busy, cnt_q, exp_val); end
        $display("cmd: id=%0d start=%0d ud=%0d steps=%0d -> value=%0d (expected %0d)", id, start, ud, steps, cnt_q, exp_val);
    endtask

    task automatic test_commands();
        run_cmd(1'b0, 4'd3,  1'b1, 5,  4'd8);
        run_cmd(1'b1, 4'd14, 1'b1, 3,  4'd1);
        run_cmd(1'b0, 4'd1,  1'b0, 2,  4'd15);
        run_cmd(1'b1, 4'd9,  1'b1, 0,  4'd9);
        run_cmd(1'b0, 4'd0,  1'b1, 20, 4'd4);
    endtask

    task automatic test_arbitration();
        int t;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        req0_valid = 1'b1; req0_start = 4'd2; req0_ud = 1'b1; req0_steps = 8'd1;
        req1_valid = 1'b1; req1_start = 4'd5; req1_ud = 1'b0; req1_steps = 8'd1;
        #1;
        for (int g = 0; g < 4; g++) begin
            t = 0;
            while (!(req0_ready || req1_ready) && t < 20) begin
                @(negedge clk); #1; t++;
            end
            checks++; if ({req1_ready, req0_ready} !== ((g % 2 == 1) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL arb_grant: got r1r0=%b%b at grant %0d expected req%0d (wait %0d)",
                                   req1_ready, req0_ready, g, g % 2, t); end
            $display("arb: grant %0d -> r1r0=%b%b", g, req1_ready, req0_ready);
            @(posedge clk); @(negedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        bit seen;
        @(negedge clk);
        req0_valid = 1'b1; req0_start = 4'd0; req0_ud = 1'b1; req0_steps = 8'd10;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done_valid !== 1'b0) begin
            errors++; $display("FAIL midrun_reset: got busy=%b done_valid=%b expected 0/0", busy, done_valid); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin
            errors++; $display("FAIL midrun_no_done: got done_valid=1 after reset expected none"); end
        req0_valid = 1'b1; req0_steps = 8'd0;
        req1_valid = 1'b1; req1_steps = 8'd0;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL midrun_tie: got r1r0=%b%b expected 01", req1_ready, req0_ready); end
        $display("midrun: reset discarded command, tie -> r1r0=%b%b", req1_ready, req0_ready);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

`ifdef COUNTER_SCHED_ABORT_EN
    task automatic test_abort();
        @(negedge clk);
        req0_valid = 1'b1; req0_start = 4'd0; req0_ud = 1'b1; req0_steps = 8'd10;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (done_valid !== 1'b1 || done_aborted !== 1'b1 || done_value !== 4'd4) begin
            errors++; $display("FAIL abort_done: got valid=%b aborted=%b value=%0d expected 1/1/4",
                               done_valid, done_aborted, done_value); end
        @(negedge clk);
        checks++; if (done_aborted !== 1'b0 || busy !== 1'b0 || cnt_q !== 4'd4) begin
            errors++; $display("FAIL abort_hold: got aborted=%b busy=%b cnt=%0d expected 0/0/4", done_aborted, busy, cnt_q); end
        $display("abort: value=%0d", cnt_q);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req0_valid = 1'b0; req0_start = '0; req0_ud = 1'b0; req0_steps = '0;
        req1_valid = 1'b0; req1_start = '0; req1_ud = 1'b0; req1_steps = '0;
`ifdef COUNTER_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_commands();
        test_arbitration();
        test_reset_midrun();
`ifdef COUNTER_SCHED_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
